// File: rtl/pr_timer.sv
// pr_timer: programmable down-counting bus timer, one-shot or auto-reload, level irq
//   clk, rst        : clock, asynchronous active-high reset
//   addr, we, wd, be: bus write side (0=CTRL, 1=PRESET, 2=COUNT read-only, 3=reserved)
//   rd              : combinational read data for addr
//   irq             : pending flag gated by CTRL.IM
module pr_timer #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] rd,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;
  state_t           r_state;
  logic [3:0]       r_ctrl;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;
  logic             r_flag;
  logic             w_ctrl_wr;
  logic             w_preset_wr;
  logic             w_auto;
  logic             w_set;
  logic [31:0]      w_preset_ext;
  logic [31:0]      w_preset_merge;
  assign w_ctrl_wr    = we && addr == 2'd0;
  assign w_preset_wr  = we && addr == 2'd1;
  assign w_auto       = r_ctrl[2:1] == 2'b01;
  // terminal count reached while enabled: this edge enters INT and raises the flag
  assign w_set        = r_state == S_CNT && r_ctrl[0] && r_count <= CNT_W'(1);
  assign w_preset_ext = 32'(r_preset);
  always_comb begin
    w_preset_merge = w_preset_ext;
    for (int i = 0; i < 4; i++)
      w_preset_merge[8*i +: 8] = be[i] ? wd[8*i +: 8] : w_preset_ext[8*i +: 8];
  end
  assign rd  = addr == 2'd0 ? {28'd0, r_ctrl} :
               addr == 2'd1 ? 32'(r_preset) :
               addr == 2'd2 ? 32'(r_count) : 32'd0;
  assign irq = r_flag & r_ctrl[3];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= r_ctrl[0] ? S_LOAD : S_IDLE;
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) r_state <= S_IDLE;
          else if (w_set) begin
            r_count <= '0;
            r_state <= S_INT;
          end else r_count <= r_count - CNT_W'(1);
        end
        S_INT: begin
          r_state <= w_auto ? S_LOAD : S_IDLE;
          if (!w_auto) r_ctrl[0] <= 1'b0;
        end
      endcase
      // set beats any clear; auto-reload INT and register writes clear
      r_flag <= w_set | (r_flag & ~(w_ctrl_wr | w_preset_wr | (r_state == S_INT && w_auto)));
      // placed after the FSM so a CPU write overrides the one-shot En clear
      if (w_ctrl_wr && be[0]) r_ctrl <= wd[3:0];
      if (w_preset_wr) r_preset <= w_preset_merge[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_pr_timer.sv
// tb_pr_timer: scoreboard-driven self-checking bench for pr_timer
module tb_pr_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [3:0]  be = 4'd0;
  logic [31:0] rd;
  logic        irq;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] sb_q[$];
  logic [31:0] got;
  logic [31:0] exp_v;

  pr_timer #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .wd(wd), .be(be), .rd(rd), .irq(irq)
  );

  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wd = d; be = b; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task read_reg(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd;
  endtask

  task do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task test_reset;
    do_reset;
    bus_write(2'd1, 32'd10, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (5) tick;
    sb_q.push_back(32'd7);
    read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_pre_count: got %h expected %h", got, exp_v); end
    rst = 1'b1;
    #1;
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd0);
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_async_irq_count: got %h expected %h", got, exp_v); end
    read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_async_count: got %h expected %h", got, exp_v); end
    tick;
    rst = 1'b0;
    tick;
    bus_write(2'd1, 32'd1, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (3) tick;
    sb_q.push_back(32'd1);
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_pre_irq: got %h expected %h", got, exp_v); end
    #2;
    rst = 1'b1;
    #1;
    sb_q.push_back(32'd0);
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL reset_async_irq: got %h expected %h", got, exp_v); end
    tick;
    tick;
    rst = 1'b0;
    tick;
    for (int a = 0; a < 3; a++) sb_q.push_back(32'd0);
    for (int a = 0; a < 3; a++) begin
      read_reg(2'(a), got); exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL reset_reg addr=%0d: got %h expected %h", a, got, exp_v); end
    end
  endtask

  task test_oneshot;
    do_reset;
    bus_write(2'd1, 32'd5, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    for (int k = 1; k <= 7; k++) begin
      sb_q.push_back(k >= 2 ? 32'(7 - k) : 32'd0);
      sb_q.push_back(k == 7 ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= 7; k++) begin
      tick;
      read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_count edge=%0d: got %h expected %h", k, got, exp_v); end
      got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_irq edge=%0d: got %h expected %h", k, got, exp_v); end
    end
    sb_q.push_back(32'h8);
    sb_q.push_back(32'd1);
    sb_q.push_back(32'd1);
    tick;
    read_reg(2'd0, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_ctrl: got %h expected %h", got, exp_v); end
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_irq_int: got %h expected %h", got, exp_v); end
    repeat (3) tick;
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_irq_hold: got %h expected %h", got, exp_v); end
    bus_write(2'd0, 32'h8, 4'hF);
    sb_q.push_back(32'd0);
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL oneshot_irq_clear: got %h expected %h", got, exp_v); end
  endtask

  task test_autoreload;
    int p;
    do_reset;
    bus_write(2'd1, 32'd3, 4'hF);
    bus_write(2'd0, 32'hB, 4'hF);
    for (int k = 1; k <= 21; k++) begin
      p = (k - 2) % 5;
      sb_q.push_back(k < 2 ? 32'd0 : (p < 3 ? 32'(3 - p) : 32'd0));
      sb_q.push_back((k >= 5 && (k - 5) % 5 == 0) ? 32'd1 : 32'd0);
      sb_q.push_back(32'hB);
    end
    for (int k = 1; k <= 21; k++) begin
      tick;
      read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL auto_count edge=%0d: got %h expected %h", k, got, exp_v); end
      got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL auto_irq edge=%0d: got %h expected %h", k, got, exp_v); end
      read_reg(2'd0, got); exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL auto_ctrl edge=%0d: got %h expected %h", k, got, exp_v); end
    end
  endtask

  task test_disable;
    do_reset;
    bus_write(2'd1, 32'd10, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (6) tick;
    sb_q.push_back(32'd6);
    read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL disable_pre: got %h expected %h", got, exp_v); end
    bus_write(2'd0, 32'h8, 4'hF);
    for (int k = 0; k < 6; k++) begin
      sb_q.push_back(32'd5);
      sb_q.push_back(32'd0);
    end
    for (int k = 0; k < 6; k++) begin
      read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL disable_count k=%0d: got %h expected %h", k, got, exp_v); end
      got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL disable_irq k=%0d: got %h expected %h", k, got, exp_v); end
      tick;
    end
    bus_write(2'd0, 32'h9, 4'hF);
    tick;
    tick;
    sb_q.push_back(32'd10);
    read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL disable_reload: got %h expected %h", got, exp_v); end
  endtask

  task test_byte_writes;
    do_reset;
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd1, 32'hAABBCCDD, 4'b0101);
    sb_q.push_back(32'h00BB00DD);
    read_reg(2'd1, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL byte_preset_lo: got %h expected %h", got, exp_v); end
    bus_write(2'd1, 32'h11223344, 4'b1010);
    sb_q.push_back(32'h11BB33DD);
    read_reg(2'd1, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL byte_preset_hi: got %h expected %h", got, exp_v); end
    bus_write(2'd2, 32'h12345678, 4'hF);
    bus_write(2'd3, 32'hFFFFFFFF, 4'hF);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'h11BB33DD);
    read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL byte_count_ro: got %h expected %h", got, exp_v); end
    read_reg(2'd3, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL byte_reserved: got %h expected %h", got, exp_v); end
    read_reg(2'd1, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL byte_preset_keep: got %h expected %h", got, exp_v); end
  endtask

  task test_boundary;
    do_reset;
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    for (int k = 1; k <= 3; k++) sb_q.push_back(k == 3 ? 32'd1 : 32'd0);
    for (int k = 1; k <= 3; k++) begin
      tick;
      got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL zero_irq edge=%0d: got %h expected %h", k, got, exp_v); end
    end
    do_reset;
    bus_write(2'd1, 32'd0, 4'hF);
    bus_write(2'd0, 32'h1, 4'hF);
    for (int k = 1; k <= 5; k++) sb_q.push_back(32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick;
      got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
      if (got !== exp_v) begin n_fail++; $display("FAIL masked_irq edge=%0d: got %h expected %h", k, got, exp_v); end
    end
    sb_q.push_back(32'h0);
    read_reg(2'd0, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL masked_ctrl: got %h expected %h", got, exp_v); end
    bus_write(2'd0, 32'h8, 4'hF);
    sb_q.push_back(32'd0);
    sb_q.push_back(32'd0);
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL masked_clear: got %h expected %h", got, exp_v); end
    tick;
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL masked_clear_hold: got %h expected %h", got, exp_v); end
  endtask

  task test_back_to_back;
    do_reset;
    bus_write(2'd1, 32'd2, 4'hF);
    bus_write(2'd0, 32'h9, 4'hF);
    repeat (3) tick;
    bus_write(2'd1, 32'd2, 4'hF);
    sb_q.push_back(32'd1);
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL b2b_set_wins: got %h expected %h", got, exp_v); end
    bus_write(2'd0, 32'h9, 4'hF);
    sb_q.push_back(32'h9);
    sb_q.push_back(32'd0);
    read_reg(2'd0, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL b2b_cpu_wins_ctrl: got %h expected %h", got, exp_v); end
    got = {31'd0, irq}; exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL b2b_irq_cleared: got %h expected %h", got, exp_v); end
    tick;
    tick;
    sb_q.push_back(32'd2);
    read_reg(2'd2, got); exp_v = sb_q.pop_front(); n_checks++;
    if (got !== exp_v) begin n_fail++; $display("FAIL b2b_restart_count: got %h expected %h", got, exp_v); end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_autoreload;
    test_disable;
    test_byte_writes;
    test_boundary;
    test_back_to_back;
    n_checks++;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
